// File: rtl/sram_2rw_param.sv
// sram_2rw_param: parametrised single-clock SRAM model with two read/write ports.
// It provides per-lane write masks, a read latency of 1 or 2 cycles, and defined
// same-address collision behaviour between the ports. A hardware clear sequence
// zeroes every row after reset, so contents are never random.
module sram_2rw_param #(
    parameter int DEPTH         = 64,
    parameter int WIDTH         = 8,
    parameter int MASK_GRAN     = 8,
    parameter int READ_LAT      = 1,
    parameter int WRITE_THROUGH = 0,
    parameter int AW            = $clog2(DEPTH),
    localparam int NL           = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset,
    output logic             init_done,
    input  logic             a_en,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [NL-1:0]    a_wmask,
    input  logic [WIDTH-1:0] a_wdata,
    output logic [WIDTH-1:0] a_rdata,
    output logic             a_rvalid,
    input  logic             b_en,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [NL-1:0]    b_wmask,
    input  logic [WIDTH-1:0] b_wdata,
    output logic [WIDTH-1:0] b_rdata,
    output logic             b_rvalid
);

    // Geometry and latency sanity checks, resolved at elaboration time
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
        $fatal(1, "sram_2rw_param: READ_LAT must be 1 or 2");
    end
    if (WIDTH % MASK_GRAN != 0) begin : g_bad_mask_gran
        $fatal(1, "sram_2rw_param: WIDTH must be a multiple of MASK_GRAN");
    end
    if (DEPTH < 2 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sram_2rw_param: DEPTH must be a power of two in 2..4096");
    end

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    clr_cnt;
    logic [AW-1:0]    clr_cnt_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             ready;
    logic             a_rd;
    logic             a_wr;
    logic             b_rd;
    logic             b_wr;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;

    // Overlay the masked lanes of new_word onto old_word
    function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_word,
                                                     input logic [NL-1:0]    mask,
                                                     input logic [WIDTH-1:0] new_word);
        logic [WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) begin
                merged[i*MASK_GRAN +: MASK_GRAN] = new_word[i*MASK_GRAN +: MASK_GRAN];
            end
        end
        return merged;
    endfunction

    // Requests count only once the clear sequence has handed over to READY
    assign ready = (state == READY);
    assign a_rd  = ready && a_en && !a_we;
    assign a_wr  = ready && a_en && a_we;
    assign b_rd  = ready && b_en && !b_we;
    assign b_wr  = ready && b_en && b_we;

    // State register, clear counter and the delayed init_done flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            init_done <= (state == READY);
        end
    end

    // Walk the clear counter through every row, then settle in READY for good
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            INIT: begin
                clr_cnt_next = clr_cnt + AW'(1);
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Array update: clear one row per cycle in INIT, otherwise masked writes with port A applied last so it wins shared lanes
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (b_wr && b_wmask[i]) begin
                    mem[b_addr][i*MASK_GRAN +: MASK_GRAN] <= b_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (a_wr && a_wmask[i]) begin
                    mem[a_addr][i*MASK_GRAN +: MASK_GRAN] <= a_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Read word per port: stored data, or the merged post-write word when the other port writes the same row in write-through mode
    always_comb begin
        a_word = mem[a_addr];
        b_word = mem[b_addr];
        if (WRITE_THROUGH != 0) begin
            if (b_wr && (b_addr == a_addr)) begin
                a_word = merge_lanes(mem[a_addr], b_wmask, b_wdata);
            end
            if (a_wr && (a_addr == b_addr)) begin
                b_word = merge_lanes(mem[b_addr], a_wmask, a_wdata);
            end
        end
    end

    if (READ_LAT == 1) begin : g_lat1
        // Single-stage read: capture the word at the request edge, hold it until the next read
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                a_rdata  <= '0;
                a_rvalid <= 1'b0;
                b_rdata  <= '0;
                b_rvalid <= 1'b0;
            end else begin
                a_rvalid <= a_rd;
                b_rvalid <= b_rd;
                if (a_rd) begin
                    a_rdata <= a_word;
                end
                if (b_rd) begin
                    b_rdata <= b_word;
                end
            end
        end
    end else begin : g_lat2
        logic             a_p_valid;
        logic             b_p_valid;
        logic [WIDTH-1:0] a_p_data;
        logic [WIDTH-1:0] b_p_data;

        // Two-stage read: an internal capture stage followed by the holding output register
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                a_p_valid <= 1'b0;
                b_p_valid <= 1'b0;
                a_p_data  <= '0;
                b_p_data  <= '0;
                a_rdata   <= '0;
                a_rvalid  <= 1'b0;
                b_rdata   <= '0;
                b_rvalid  <= 1'b0;
            end else begin
                a_p_valid <= a_rd;
                b_p_valid <= b_rd;
                if (a_rd) begin
                    a_p_data <= a_word;
                end
                if (b_rd) begin
                    b_p_data <= b_word;
                end
                a_rvalid <= a_p_valid;
                b_rvalid <= b_p_valid;
                if (a_p_valid) begin
                    a_rdata <= a_p_data;
                end
                if (b_p_valid) begin
                    b_rdata <= b_p_data;
                end
            end
        end
    end

endmodule
